regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 94 +++++++++
 tb/tb_regfile_param.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with optional zero register,
// optional write-to-read bypass and a one-entry-per-cycle clear engine.
module regfile_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [31:0]       DEPTH_U = DEPTH;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH_U;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign clr_busy = (state == S_CLEAR);

    // rst_n gates the bypass so reads stay 0 while reset is held
    assign wr_ok = rst_n && we && !clr_busy
                && in_range(wr) && !is_zero_reg(wr);

    function automatic logic [WIDTH-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (in_range(a) && !is_zero_reg(a)) begin
            if ((BYPASS != 0) && wr_ok && (wr == a)) v = wd;
            else                                      v = mem[a];
        end
        return v;
    endfunction

    always_comb begin
        rd1 = rd_val(rr1);
        rd2 = rd_val(rr2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (wr_ok) mem[wr] <= wd;
                    if (clr_req) begin
                        state <= S_CLEAR;
                        idx   <= '0;
                    end
                end
                S_CLEAR: begin
                    mem[idx] <= '0;
                    if (idx == LAST) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param across four parameter sets sharing
// one stimulus bus: default, no bypass, zero register, depth 5.
module tb_regfile_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wr = '0;
    logic [7:0] wd = '0;
    logic [2:0] rr1 = '0;
    logic [2:0] rr2 = '0;
    logic       clr_req = 1'b0;

    logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_z, rd2_z, rd1_5, rd2_5;
    logic       busy_a, busy_b, busy_z, busy_5;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e;

    always #10 clk = ~clk;

    regfile_param u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr[1:0]), .wd(wd),
        .rr1(rr1[1:0]), .rr2(rr2[1:0]), .rd1(rd1_a), .rd2(rd2_a),
        .clr_req(clr_req), .clr_busy(busy_a)
    );

    regfile_param #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr[1:0]), .wd(wd),
        .rr1(rr1[1:0]), .rr2(rr2[1:0]), .rd1(rd1_b), .rd2(rd2_b),
        .clr_req(clr_req), .clr_busy(busy_b)
    );

    regfile_param #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr[1:0]), .wd(wd),
        .rr1(rr1[1:0]), .rr2(rr2[1:0]), .rd1(rd1_z), .rd2(rd2_z),
        .clr_req(clr_req), .clr_busy(busy_z)
    );

    regfile_param #(.DEPTH(5)) u_5 (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr), .wd(wd),
        .rr1(rr1), .rr2(rr2), .rd1(rd1_5), .rd2(rd2_5),
        .clr_req(clr_req), .clr_busy(busy_5)
    );

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wr = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b1; wr = 3'd1; wd = 8'hFF;
        #3;
        for (int a = 0; a < 4; a++) begin
            rr1 = 3'(a); rr2 = 3'(a);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            #1;
            e = exp_q.pop_front(); checks++;
            if (rd1_a !== e) begin
                failures++;
                $display("FAIL reset_rd1[%0d] got=%h exp=%h", a, rd1_a, e);
            end
            e = exp_q.pop_front(); checks++;
            if (rd2_a !== e) begin
                failures++;
                $display("FAIL reset_rd2[%0d] got=%h exp=%h", a, rd2_a, e);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy_a);
        end
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_write(3'd2, 8'hA5);
        do_write(3'd3, 8'h3C);
        rr1 = 3'd2; rr2 = 3'd3;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin
            failures++;
            $display("FAIL basic_rd1 got=%h exp=%h", rd1_a, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd2_a !== e) begin
            failures++;
            $display("FAIL basic_rd2 got=%h exp=%h", rd2_a, e);
        end
    endtask

    task automatic test_bypass();
        do_write(3'd1, 8'h11);
        @(negedge clk);
        we = 1'b1; wr = 3'd1; wd = 8'h77; rr1 = 3'd1; rr2 = 3'd1;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h11);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin
            failures++;
            $display("FAIL byp_pre_rd1 got=%h exp=%h", rd1_a, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd2_a !== e) begin
            failures++;
            $display("FAIL byp_pre_rd2 got=%h exp=%h", rd2_a, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd1_b !== e) begin
            failures++;
            $display("FAIL nobyp_pre_rd1 got=%h exp=%h", rd1_b, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd2_b !== e) begin
            failures++;
            $display("FAIL nobyp_pre_rd2 got=%h exp=%h", rd2_b, e);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h77);
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin
            failures++;
            $display("FAIL byp_post_rd1 got=%h exp=%h", rd1_a, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd1_b !== e) begin
            failures++;
            $display("FAIL nobyp_post_rd1 got=%h exp=%h", rd1_b, e);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; wr = 3'd0; wd = 8'hFF; rr1 = 3'd0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_z !== e) begin
            failures++;
            $display("FAIL zero_pre got=%h exp=%h", rd1_z, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin
            failures++;
            $display("FAIL nozero_pre got=%h exp=%h", rd1_a, e);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        e = exp_q.pop_front(); checks++;
        if (rd1_z !== e) begin
            failures++;
            $display("FAIL zero_post got=%h exp=%h", rd1_z, e);
        end
        do_write(3'd1, 8'hFF);
        rr1 = 3'd1;
        exp_q.push_back(8'hFF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_z !== e) begin
            failures++;
            $display("FAIL zero_r1 got=%h exp=%h", rd1_z, e);
        end
    endtask

    task automatic test_depth5();
        for (int k = 0; k < 5; k++) do_write(3'(k), 8'(8'h10 + k));
        @(negedge clk);
        we = 1'b1; wr = 3'd6; wd = 8'h55; rr1 = 3'd6;
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_5 !== e) begin
            failures++;
            $display("FAIL d5_oor_pre got=%h exp=%h", rd1_5, e);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        e = exp_q.pop_front(); checks++;
        if (rd1_5 !== e) begin
            failures++;
            $display("FAIL d5_oor_post got=%h exp=%h", rd1_5, e);
        end
        for (int k = 0; k < 5; k++) begin
            rr1 = 3'(k);
            exp_q.push_back(8'(8'h10 + k));
            #1;
            e = exp_q.pop_front(); checks++;
            if (rd1_5 !== e) begin
                failures++;
                $display("FAIL d5_keep[%0d] got=%h exp=%h", k, rd1_5, e);
            end
        end
        do_write(3'd4, 8'h99);
        rr1 = 3'd4;
        exp_q.push_back(8'h99);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_5 !== e) begin
            failures++;
            $display("FAIL d5_r4 got=%h exp=%h", rd1_5, e);
        end
    endtask

    task automatic test_clear();
        logic eb;
        for (int k = 0; k < 4; k++) do_write(3'(k), 8'hEE);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 5; j++) begin
            #1;
            eb = (j == 4) ? 1'b0 : 1'b1;
            checks++;
            if (busy_a !== eb) begin
                failures++;
                $display("FAIL clr_busy[N+%0d] got=%b exp=%b", j, busy_a, eb);
            end
            for (int k = 0; k < 4; k++) begin
                rr1 = 3'(k);
                exp_q.push_back((k < j) ? 8'h00 : 8'hEE);
                #1;
                e = exp_q.pop_front(); checks++;
                if (rd1_a !== e) begin
                    failures++;
                    $display("FAIL clr_r%0d[N+%0d] got=%h exp=%h",
                             k, j, rd1_a, e);
                end
            end
            if (j == 1) begin
                we = 1'b1; wr = 3'd3; wd = 8'h42; rr2 = 3'd3;
                exp_q.push_back(8'hEE);
                #1;
                e = exp_q.pop_front(); checks++;
                if (rd2_a !== e) begin
                    failures++;
                    $display("FAIL clr_nobyp got=%h exp=%h", rd2_a, e);
                end
            end
            if (j == 2) we = 1'b0;
            if (j < 5) @(posedge clk);
        end
        @(negedge clk);
        clr_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL clr_done got=%b exp=0", busy_a);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 0; k < 4; k++) do_write(3'(k), 8'hEE);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=0", busy_a);
        end
        for (int k = 0; k < 4; k++) begin
            rr1 = 3'(k);
            exp_q.push_back(8'h00);
            #1;
            e = exp_q.pop_front(); checks++;
            if (rd1_a !== e) begin
                failures++;
                $display("FAIL mid_r%0d got=%h exp=%h", k, rd1_a, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(3'd1, 8'h5A);
        rr1 = 3'd1; rr2 = 3'd2;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin
            failures++;
            $display("FAIL mid_wr got=%h exp=%h", rd1_a, e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd2_a !== e) begin
            failures++;
            $display("FAIL mid_r2 got=%h exp=%h", rd2_a, e);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle got=%b exp=0", busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_depth5();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
